// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf: instruction-fetch front end between the core and the instruction ROM.
// Issues sequential ROM reads from an internal fetch PC, tracks requests in flight through a
// ROM_LAT-deep shift register and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO.
// A flush redirects fetch and drops everything buffered or in flight.
//
// Ports:
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   rom_ce_o, rom_addr_o        ROM read request and address (address is the fetch PC)
//   rom_data_i                  ROM read data, valid ROM_LAT cycles after a request
//   flush_i, flush_pc_i         redirect fetch to flush_pc_i, highest priority
//   inst_valid_o, inst_o,
//   inst_pc_o, inst_ready_i     head-of-FIFO handshake towards the core
//   count_o                     FIFO occupancy
module inst_prefetch_buf #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [DATA_W-1:0]          rom_data_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          flush_pc_i,
  output logic                       inst_valid_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_pc_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Fetch PC
  logic [ADDR_W-1:0] pc_q;

  // In-flight tracking: stage 0 is the request issued last cycle
  logic [ROM_LAT-1:0] fl_vld_q;
  logic [ADDR_W-1:0]  fl_pc_q [ROM_LAT];

  // FIFO storage, entries are {pc, inst}
  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          count_q;

  logic [CntW:0] inflight;
  logic [CntW:0] occupancy;
  logic          credit;
  logic          issue;
  logic          push;
  logic          pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + {{CntW{1'b0}}, fl_vld_q[i]};
    end
  end

  // Credit counts only committed state; a same-cycle pop does not free a slot, which keeps
  // count + inflight <= DEPTH and makes an overflowing push impossible.
  assign occupancy = {1'b0, count_q} + inflight;
  assign credit    = occupancy < (CntW + 1)'(DEPTH);
  assign issue     = ~rst & ~flush_i & credit;
  assign push      = fl_vld_q[ROM_LAT-1];

  assign inst_valid_o = (count_q != '0) & ~flush_i & ~rst;
  assign pop          = inst_valid_o & inst_ready_i;

  assign rom_ce_o = issue;
  // Show RESET_PC while in reset even before the first reset edge has loaded pc_q.
  assign rom_addr_o = rst ? RESET_PC : pc_q;
  assign count_o    = rst ? '0 : count_q;

  assign inst_o    = mem_q[rd_ptr_q][DATA_W-1:0];
  assign inst_pc_o = mem_q[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W];

  // Control state: reset and flush discard everything identically.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      pc_q     <= rst ? RESET_PC : flush_pc_i;
      fl_vld_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (issue) begin
        pc_q <= pc_q + ADDR_W'(4);
      end
      fl_vld_q[0] <= issue;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        fl_vld_q[i] <= fl_vld_q[i-1];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Datapath without reset; stale contents are masked by the valid bits and count.
  always_ff @(posedge clk) begin
    fl_pc_q[0] <= pc_q;
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      fl_pc_q[i] <= fl_pc_q[i-1];
    end
    if (push && !rst && !flush_i) begin
      mem_q[wr_ptr_q] <= {fl_pc_q[ROM_LAT-1], rom_data_i};
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
module tb_inst_prefetch_buf;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: DEPTH=4, ROM_LAT=1, RESET_PC=0x100
  logic        rst_a, flush_a, ready_a, ce_a, valid_a;
  logic [31:0] fpc_a, addr_a, rdata_a, inst_a, ipc_a, a_d1;
  logic [2:0]  count_a;

  inst_prefetch_buf #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (4),
    .ROM_LAT (1),
    .RESET_PC(32'h0000_0100)
  ) u_a (
    .clk         (clk),
    .rst         (rst_a),
    .rom_ce_o    (ce_a),
    .rom_addr_o  (addr_a),
    .rom_data_i  (rdata_a),
    .flush_i     (flush_a),
    .flush_pc_i  (fpc_a),
    .inst_valid_o(valid_a),
    .inst_o      (inst_a),
    .inst_pc_o   (ipc_a),
    .inst_ready_i(ready_a),
    .count_o     (count_a)
  );

  // Instance B: DEPTH=8, ROM_LAT=3, RESET_PC=0
  logic        rst_b, flush_b, ready_b, ce_b, valid_b;
  logic [31:0] fpc_b, addr_b, rdata_b, inst_b, ipc_b;
  logic [31:0] b_d [3];
  logic [3:0]  count_b;

  inst_prefetch_buf #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (8),
    .ROM_LAT (3),
    .RESET_PC(32'h0000_0000)
  ) u_b (
    .clk         (clk),
    .rst         (rst_b),
    .rom_ce_o    (ce_b),
    .rom_addr_o  (addr_b),
    .rom_data_i  (rdata_b),
    .flush_i     (flush_b),
    .flush_pc_i  (fpc_b),
    .inst_valid_o(valid_b),
    .inst_o      (inst_b),
    .inst_pc_o   (ipc_b),
    .inst_ready_i(ready_b),
    .count_o     (count_b)
  );

  // ROM models: data = 0xA000_0000 | address, delayed by the ROM latency
  always @(posedge clk) begin
    a_d1   <= addr_a;
    b_d[0] <= addr_b;
    b_d[1] <= b_d[0];
    b_d[2] <= b_d[1];
  end
  assign rdata_a = 32'hA000_0000 | a_d1;
  assign rdata_b = 32'hA000_0000 | b_d[2];

  // Scoreboards: expected PC stream per instance
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  int pops_a = 0;
  int pops_b = 0;

  task automatic fill_a(input logic [31:0] start);
    q_a.delete();
    for (int i = 0; i < 64; i++) q_a.push_back(start + 32'(4 * i));
  endtask

  task automatic fill_b(input logic [31:0] start);
    q_b.delete();
    for (int i = 0; i < 64; i++) q_b.push_back(start + 32'(4 * i));
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (valid_a && ready_a) begin
      pops_a++;
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected: got pc %h want none", ipc_a);
      end else begin
        e = q_a.pop_front();
        chk("a_pc", ipc_a, e);
        chk("a_inst", inst_a, 32'hA000_0000 | e);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (valid_b && ready_b) begin
      pops_b++;
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected: got pc %h want none", ipc_b);
      end else begin
        e = q_b.pop_front();
        chk("b_pc", ipc_b, e);
        chk("b_inst", inst_b, 32'hA000_0000 | e);
      end
    end
  end

  logic done_a = 1'b0;
  logic done_b = 1'b0;

  // Instance A: startup, backpressure, toggling ready, reset mid-stream, wrapping flush
  initial begin
    int n;
    int base;
    rst_a = 1'b1; flush_a = 1'b0; fpc_a = '0; ready_a = 1'b1;
    tick();
    tick();
    #3;
    chk("a_rst_ce", ce_a, 0);
    chk("a_rst_cnt", count_a, 0);
    chk("a_rst_valid", valid_a, 0);
    chk("a_rst_addr", addr_a, 32'h100);

    tick(); rst_a = 1'b0; fill_a(32'h100);              // cycle 0
    #3;
    chk("a_c0_ce", ce_a, 1);
    chk("a_c0_addr", addr_a, 32'h100);
    chk("a_c0_valid", valid_a, 0);
    tick(); #3;                                           // cycle 1
    chk("a_c1_valid", valid_a, 0);
    chk("a_c1_addr", addr_a, 32'h104);
    tick(); #3;                                           // cycle 2
    chk("a_c2_valid", valid_a, 1);
    chk("a_c2_pc", ipc_a, 32'h100);
    chk("a_c2_cnt", count_a, 1);
    repeat (3) tick();

    // Backpressure: from steady state (count 1, one in flight) two more issues fit
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); ready_a = 1'b0; #3;
      if (ce_a) n++;
    end
    chk("a_bp_issues", n, 2);
    chk("a_bp_cnt", count_a, 4);
    chk("a_bp_ce", ce_a, 0);
    chk("a_bp_valid", valid_a, 1);

    for (int i = 0; i < 4; i++) begin
      tick(); ready_a = 1'b1; #3;
      chk("a_drain_nogap", valid_a, 1);
    end

    for (int i = 0; i < 8; i++) begin
      tick(); ready_a = (i % 2) == 0; #3;
      chk("a_toggle_cnt_le4", count_a <= 3'd4, 1);
    end

    // Fill to 4, pop once -> count 3, then reset
    for (int i = 0; i < 10; i++) begin
      tick(); ready_a = 1'b0;
    end
    tick(); ready_a = 1'b1;
    tick();
    chk("a_pre_rst_cnt", count_a, 3);
    rst_a = 1'b1; ready_a = 1'b0; fill_a(32'h100);
    #3;
    chk("a_mid_rst_cnt", count_a, 0);
    chk("a_mid_rst_ce", ce_a, 0);
    chk("a_mid_rst_valid", valid_a, 0);
    tick(); rst_a = 1'b0; ready_a = 1'b1; #3;
    chk("a_restart_ce", ce_a, 1);
    chk("a_restart_addr", addr_a, 32'h100);
    repeat (5) tick();

    // Flush to an address that wraps
    tick(); flush_a = 1'b1; fpc_a = 32'hFFFF_FFF8; fill_a(32'hFFFF_FFF8); #3;
    chk("a_fl_valid", valid_a, 0);
    chk("a_fl_ce", ce_a, 0);
    tick(); flush_a = 1'b0; #3;
    chk("a_f1_ce", ce_a, 1);
    chk("a_f1_addr", addr_a, 32'hFFFF_FFF8);
    tick(); #3;
    chk("a_f2_valid", valid_a, 0);
    chk("a_f2_addr", addr_a, 32'hFFFF_FFFC);
    tick();
    base = pops_a;
    #3;
    chk("a_f3_valid", valid_a, 1);
    chk("a_f3_pc", ipc_a, 32'hFFFF_FFF8);
    repeat (4) tick();
    tick();
    chk("a_wrap_pops", 32'(pops_a - base), 5);
    done_a = 1'b1;
  end

  // Instance B: flush with three requests in flight and two buffered
  initial begin
    int base;
    rst_b = 1'b1; flush_b = 1'b0; fpc_b = '0; ready_b = 1'b0;
    tick();
    tick();
    tick(); rst_b = 1'b0; fill_b(32'h0); #3;              // cycle 0
    chk("b_c0_ce", ce_b, 1);
    repeat (3) tick();
    tick(); #3;                                           // cycle 4
    chk("b_c4_cnt", count_b, 1);
    tick(); flush_b = 1'b1; fpc_b = 32'h2000; ready_b = 1'b1; fill_b(32'h2000); #3;  // cycle 5
    chk("b_fl_cnt", count_b, 2);
    chk("b_fl_valid", valid_b, 0);
    chk("b_fl_ce", ce_b, 0);
    tick(); flush_b = 1'b0; #3;                           // cycle 6
    chk("b_f1_ce", ce_b, 1);
    chk("b_f1_addr", addr_b, 32'h2000);
    chk("b_f1_valid", valid_b, 0);
    for (int i = 0; i < 3; i++) begin                     // cycles 7..9
      tick(); #3;
      chk("b_wait_valid", valid_b, 0);
    end
    tick();                                               // cycle 10
    base = pops_b;
    #3;
    chk("b_f5_valid", valid_b, 1);
    chk("b_f5_pc", ipc_b, 32'h2000);
    repeat (5) tick();
    tick();
    chk("b_stream_pops", 32'(pops_b - base), 6);
    done_b = 1'b1;
  end

  initial begin
    for (int i = 0; i < 2000 && !(done_a && done_b); i++) @(posedge clk);
    if (!(done_a && done_b)) begin
      total++;
      bad++;
      $display("FAIL timeout: got done=%0b%0b want 11", done_a, done_b);
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
